// File: rtl/i2c_slave_if.sv
// Local-side handshake of the I2C target: bytes handed to and from the host logic.
// The open-drain pins stay on the target module itself so the tristate net lives at the pad.
interface i2c_slave_if;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       rw;
    logic       busy;

    modport slave (
        input  tx_data,
        output rx_data,
        output rx_valid,
        output tx_req,
        output rw,
        output busy
    );

    modport master (
        output tx_data,
        input  rx_data,
        input  rx_valid,
        input  tx_req,
        input  rw,
        input  busy
    );
endinterface

// File: rtl/i2c_slave.sv
// 7-bit-address I2C target: oversamples scl/sda, detects START/STOP, shifts write bytes in
// and read bytes out, driving sda open-drain (low or released, never high).
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'b0110110,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    i2c_slave_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WRITE,
        S_WRITE_ACK,
        S_READ,
        S_MACK,
        S_WAIT_STOP
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic [3:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_sda_oe;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_tx_req;
    logic                   r_rw;

    logic       w_scl_s;
    logic       w_sda_s;
    logic       w_start;
    logic       w_stop;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic [7:0] w_byte;

    assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
    assign w_start    = w_scl_s & r_sda_d & ~w_sda_s;
    assign w_stop     = w_scl_s & ~r_sda_d & w_sda_s;
    assign w_scl_rise = w_scl_s & ~r_scl_d;
    assign w_scl_fall = ~w_scl_s & r_scl_d;
    assign w_byte     = {r_shift[6:0], w_sda_s};

    assign sda          = r_sda_oe ? 1'b0 : 1'bz;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.tx_req   = r_tx_req;
    assign bus.rw       = r_rw;
    assign bus.busy     = (r_state != S_IDLE);

    // Presetting to 1 makes the idle bus look idle straight out of reset (no false START).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the previous stage's old value,
            // which is what makes this a shift chain rather than a single wire.
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
            r_scl_d    <= w_scl_s;
            r_sda_d    <= w_sda_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_rw       <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            if (w_start) begin
                r_state   <= S_ADDR;
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_sda_oe <= 1'b0;
                    end
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= 4'd0;
                                if (w_byte[7:1] == SLAVE_ADDR) begin
                                    r_rw    <= w_byte[0];
                                    r_state <= S_ADDR_ACK;
                                end else begin
                                    r_state <= S_WAIT_STOP;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    // bit counter 0: waiting to drive ACK; 1: ACK on the bus, waiting to release
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd0) begin
                                r_sda_oe  <= 1'b1;
                                r_bit_cnt <= 4'd1;
                            end else if (r_rw) begin
                                r_tx_req  <= 1'b1;
                                r_shift   <= {bus.tx_data[6:0], 1'b0};
                                r_sda_oe  <= ~bus.tx_data[7];
                                r_bit_cnt <= 4'd1;
                                r_state   <= S_READ;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= S_WRITE;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
                            r_shift <= w_byte;
                            if (r_bit_cnt == 4'd7) begin
                                r_rx_data  <= w_byte;
                                r_rx_valid <= 1'b1;
                                r_bit_cnt  <= 4'd8;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                            r_sda_oe  <= 1'b1;
                            r_bit_cnt <= 4'd0;
                            r_state   <= S_WRITE_ACK;
                        end
                    end
                    S_WRITE_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_state  <= S_WRITE;
                        end
                    end
                    // bit counter holds how many bits of the current byte are already on the bus
                    S_READ: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= S_MACK;
                            end else begin
                                r_sda_oe  <= ~r_shift[7];
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_MACK: begin
                        if (w_scl_rise) begin
                            if (w_sda_s) begin
                                r_state <= S_WAIT_STOP;
                            end else begin
                                r_bit_cnt <= 4'd1;
                            end
                        end else if (w_scl_fall && (r_bit_cnt == 4'd1)) begin
                            r_tx_req  <= 1'b1;
                            r_shift   <= {bus.tx_data[6:0], 1'b0};
                            r_sda_oe  <= ~bus.tx_data[7];
                            r_bit_cnt <= 4'd1;
                            r_state   <= S_READ;
                        end
                    end
                    S_WAIT_STOP: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: an open-drain bus master built from tasks, a table of single-byte
// transactions, hand-written burst/repeated-START/reset sequences, and random transactions.
module tb_i2c_slave;
    localparam logic [6:0] SLAVE = 7'h36;
    localparam int         SYNC  = 2;
    localparam int         Q     = 6;

    logic clk = 1'b0;
    logic reset;
    logic scl_m;
    logic m_sda_oe;
    wire  sda;

    i2c_slave_if bus();

    assign sda = m_sda_oe ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave #(
        .SLAVE_ADDR (SLAVE),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .scl  (scl_m),
        .sda  (sda),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Passive monitor: collects written bytes, counts tx_req pulses and target-driven lows.
    logic [7:0] rx_q[$];
    int   tx_cnt    = 0;
    int   slave_low = 0;
    int   pulse_err = 0;
    logic prev_rx   = 1'b0;
    logic prev_tx   = 1'b0;

    always begin
        @(negedge clk);
        #1;
        if (bus.rx_valid === 1'b1) rx_q.push_back(bus.rx_data);
        if (bus.tx_req === 1'b1) tx_cnt++;
        if (sda === 1'b0 && m_sda_oe === 1'b0) slave_low++;
        if (bus.rx_valid === 1'b1 && bus.tx_req === 1'b1) pulse_err++;
        if (bus.rx_valid === 1'b1 && prev_rx) pulse_err++;
        if (bus.tx_req === 1'b1 && prev_tx) pulse_err++;
        prev_rx = (bus.rx_valid === 1'b1);
        prev_tx = (bus.tx_req === 1'b1);
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    // Master primitives. Every bit leaves scl low; sda changes mid-low, sampled mid-high.
    task automatic i2c_bit(input logic b, output logic s);
        repeat (Q) @(negedge clk);
        m_sda_oe = ~b;
        repeat (Q) @(negedge clk);
        scl_m = 1'b1;
        repeat (Q) @(negedge clk);
        s = sda;
        repeat (Q) @(negedge clk);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        repeat (Q) @(negedge clk);
        m_sda_oe = 1'b0;
        repeat (Q) @(negedge clk);
        scl_m = 1'b1;
        repeat (Q) @(negedge clk);
        m_sda_oe = 1'b1;
        repeat (Q) @(negedge clk);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        repeat (Q) @(negedge clk);
        m_sda_oe = 1'b1;
        repeat (Q) @(negedge clk);
        scl_m = 1'b1;
        repeat (Q) @(negedge clk);
        m_sda_oe = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
        i2c_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic [7:0] next_tx, input logic m_ack,
                             output logic [7:0] b, output logic nine);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, s);
            b[i] = s;
            if (i == 7) bus.tx_data = next_tx;
        end
        i2c_bit(~m_ack, nine);
    endtask

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] data;
        logic       exp_ack;
        int         exp_rx;
        int         exp_tx;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic       ack;
        logic       nine;
        logic [7:0] b;
        int         rx0;
        int         tx0;
        int         low0;
        logic [6:0] addr;
        logic       is_read;
        logic       match;
        int         len;
        logic [7:0] d   [4];
        logic [7:0] txv [5];
        logic [7:0] exp_rx[$];

        vecs[0] = '{8'h6C, 8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h6D, 8'h5A, 1'b1, 0, 1, 8'h5A};
        vecs[2] = '{8'h6E, 8'hFF, 1'b0, 0, 0, 8'hFF};
        vecs[3] = '{8'h6C, 8'h00, 1'b1, 1, 0, 8'h00};
        vecs[4] = '{8'h6D, 8'h81, 1'b1, 0, 1, 8'h81};
        vecs[5] = '{8'h6F, 8'h3C, 1'b0, 0, 0, 8'hFF};
        vecs[6] = '{8'h4C, 8'h12, 1'b0, 0, 0, 8'h12};
        vecs[7] = '{8'h6D, 8'hFF, 1'b1, 0, 1, 8'hFF};

        reset       = 1'b1;
        scl_m       = 1'b1;
        m_sda_oe    = 1'b0;
        bus.tx_data = 8'h00;
        repeat (10) @(negedge clk);
        check("reset_sda_released", sda, 1'b1);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_rx_data", bus.rx_data, 8'h00);
        check("reset_rx_valid", bus.rx_valid, 1'b0);
        check("reset_tx_req", bus.tx_req, 1'b0);
        check("reset_rw", bus.rw, 1'b0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            rx0  = rx_q.size();
            tx0  = tx_cnt;
            low0 = slave_low;
            bus.tx_data = vecs[i].data;
            i2c_start();
            write_byte(vecs[i].addr_byte, ack);
            check($sformatf("vec%0d_addr_ack", i), ack, vecs[i].exp_ack);
            if (vecs[i].addr_byte[0]) begin
                read_byte(8'h00, 1'b0, b, nine);
                check($sformatf("vec%0d_read_byte", i), b, vecs[i].exp_byte);
                check($sformatf("vec%0d_ninth_released", i), nine, 1'b1);
            end else begin
                write_byte(vecs[i].data, ack);
                check($sformatf("vec%0d_data_ack", i), ack, vecs[i].exp_ack);
            end
            check($sformatf("vec%0d_busy_before_stop", i), bus.busy, 1'b1);
            i2c_stop();
            check($sformatf("vec%0d_busy_after_stop", i), bus.busy, 1'b0);
            check($sformatf("vec%0d_rx_count", i), rx_q.size() - rx0, vecs[i].exp_rx);
            check($sformatf("vec%0d_tx_count", i), tx_cnt - tx0, vecs[i].exp_tx);
            if (vecs[i].exp_rx != 0)
                check($sformatf("vec%0d_rx_data", i), rx_q[rx_q.size()-1], vecs[i].exp_byte);
            if (vecs[i].exp_ack)
                check($sformatf("vec%0d_rw", i), bus.rw, vecs[i].addr_byte[0]);
            else
                check($sformatf("vec%0d_never_driven", i), slave_low - low0, 0);
            repeat (Q) @(negedge clk);
        end

        // Burst read: second byte is presented only after the first tx_req.
        tx0 = tx_cnt;
        bus.tx_data = 8'h11;
        i2c_start();
        write_byte(8'h6D, ack);
        check("burst_addr_ack", ack, 1'b1);
        read_byte(8'h22, 1'b1, b, nine);
        check("burst_byte0", b, 8'h11);
        read_byte(8'h00, 1'b0, b, nine);
        check("burst_byte1", b, 8'h22);
        check("burst_released", nine, 1'b1);
        i2c_stop();
        check("burst_tx_count", tx_cnt - tx0, 2);
        repeat (Q) @(negedge clk);

        // Repeated START after four data bits of a write, then a read.
        rx0 = rx_q.size();
        tx0 = tx_cnt;
        i2c_start();
        write_byte(8'h6C, ack);
        check("rs_write_addr_ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) i2c_bit(i[0], nine);
        bus.tx_data = 8'hC3;
        i2c_start();
        write_byte(8'h6D, ack);
        check("rs_read_addr_ack", ack, 1'b1);
        read_byte(8'h00, 1'b0, b, nine);
        check("rs_read_byte", b, 8'hC3);
        i2c_stop();
        check("rs_no_partial_rx", rx_q.size() - rx0, 0);
        check("rs_tx_count", tx_cnt - tx0, 1);
        check("rs_rw", bus.rw, 1'b1);
        repeat (Q) @(negedge clk);

        // Reset while the target is driving a 0 read bit.
        bus.tx_data = 8'h00;
        i2c_start();
        write_byte(8'h6D, ack);
        check("rst_addr_ack", ack, 1'b1);
        repeat (Q) @(negedge clk);
        check("rst_bit_driven_low", sda, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_sda_released", sda, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        i2c_stop();
        check("rst_idle_after", bus.busy, 1'b0);
        repeat (Q) @(negedge clk);

        // Random transactions against a transaction-level model.
        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 3) != 0) begin
                addr = SLAVE;
            end else begin
                addr = 7'($urandom_range(0, 127));
                if (addr == SLAVE) addr = addr ^ 7'h01;
            end
            is_read = 1'($urandom_range(0, 1));
            len     = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
            for (int k = 0; k < 5; k++) txv[k] = 8'($urandom);
            match = (addr == SLAVE);
            exp_rx.delete();
            rx0 = rx_q.size();
            tx0 = tx_cnt;

            bus.tx_data = txv[0];
            i2c_start();
            write_byte({addr, is_read}, ack);
            check($sformatf("rand%0d_addr_ack", t), ack, match);
            for (int k = 0; k < len; k++) begin
                if (is_read) begin
                    read_byte(txv[k+1], (k != len - 1), b, nine);
                    check($sformatf("rand%0d_rd%0d", t, k), b, match ? txv[k] : 8'hFF);
                    if (k == len - 1) check($sformatf("rand%0d_released", t), nine, 1'b1);
                end else begin
                    write_byte(d[k], ack);
                    check($sformatf("rand%0d_wr_ack%0d", t, k), ack, match);
                    if (match) exp_rx.push_back(d[k]);
                end
            end
            i2c_stop();
            check($sformatf("rand%0d_busy_after_stop", t), bus.busy, 1'b0);
            check($sformatf("rand%0d_rx_count", t), rx_q.size() - rx0, exp_rx.size());
            for (int k = 0; k < exp_rx.size(); k++)
                check($sformatf("rand%0d_rx%0d", t, k), rx_q[rx0 + k], exp_rx[k]);
            check($sformatf("rand%0d_tx_count", t), tx_cnt - tx0, (match && is_read) ? len : 0);
            if (match) check($sformatf("rand%0d_rw", t), bus.rw, is_read);
            repeat (Q) @(negedge clk);
        end

        check("pulse_rules", pulse_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- 7-bit-address I2C target (slave): the bus-side counterpart of the I2C master.
- Oversamples `scl`/`sda` on the system clock and detects START, repeated START and STOP.
- Matches its address, receives write bytes and returns read bytes, driving `sda` open-drain.
- Sits on the same bus as the master; used as a bench/SoC peripheral endpoint.

Parameters:
- `SLAVE_ADDR`, default 7'b0110110, 7-bit address this target responds to.
- `SYNC_STAGES`, default 2, number of flip-flop synchroniser stages on `scl` and `sda` inputs (minimum 2).

Ports:
- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `scl` input 1: I2C clock from master (target never stretches).
- `sda` inout 1: I2C data, open-drain: driven 1'b0 or 1'bz only, never 1'b1.
- `tx_data` input 8: byte to return on the next read byte, sampled when `tx_req` pulses.
- `rx_data` output 8: last byte written by master.
- `rx_valid` output 1: one-cycle pulse, `rx_data` updated this cycle.
- `tx_req` output 1: one-cycle pulse, `tx_data` latched into shift register this cycle.
- `rw` output 1: R/W bit of last matched address (1 = read).
- `busy` output 1: high whenever state != IDLE.

Behaviour:
- **Reset** (synchronous): state IDLE, `sda` released (z), `rx_data` = 0, `rx_valid` = 0, `tx_req` = 0, `rw` = 0, `busy` = 0, bit counter 0. Synchronisers preset to 1.
- **Synchronisation and edge detection:**
  - `scl_s`/`sda_s` are `SYNC_STAGES`-deep synchronised copies, plus one delayed copy for edge detect.
  - Latency from pin to event is `SYNC_STAGES`+1 clk.
  - Bus `scl` high and low phases must each be ≥ `SYNC_STAGES`+3 clk.
- **Bus events:**
  - START: `sda_s` falls while `scl_s` high. Accepted in every state, including mid-byte (repeated START). Goes to ADDR, bit counter = 0, `sda` released the same cycle.
  - STOP: `sda_s` rises while `scl_s` high. Goes to IDLE from any state, `sda` released.
  - START/STOP take priority over scl edges detected in the same cycle.
- **Timing rules:**
  - Data sampled on `scl_s` rising edge, MSB first.
  - Target changes its `sda` drive only on `scl_s` falling edge.
- **States:**
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W). After 8th rising edge: on match, latch `rw` and go to ADDR_ACK; on mismatch go to WAIT_STOP (no ACK, `sda` stays z).
  - ADDR_ACK: on falling edge drive `sda` low. On the following falling edge release:
    - `rw`=0: go to WRITE.
    - `rw`=1: pulse `tx_req`, load `tx_data`, drive MSB, go to READ.
  - WRITE: shift 8 bits. On 8th rising edge `rx_data` ← byte and `rx_valid` pulses the same cycle. Next falling edge drives ACK low (target always ACKs writes), go to WRITE_ACK.
  - WRITE_ACK: on falling edge release `sda`, go to WRITE for next byte. Unlimited bytes.
  - READ: on each falling edge drive next bit (0 → low, 1 → z). After the 8th bit's falling edge release `sda`, go to MACK.
  - MACK: sample `sda` on rising edge.
    - Low (ACK): on next falling edge pulse `tx_req`, load `tx_data`, drive MSB, go to READ.
    - High (NACK): go to WAIT_STOP.
  - WAIT_STOP: `sda` released; leave only on START or STOP.
- **Reset mid-transaction:** `sda` released on the cycle after `reset` is sampled high. Bus activity during reset is ignored; the target resynchronises at the next START.
- `rx_valid` and `tx_req` are never high in the same cycle and never high for more than one clk.

Test Plan:
1. Reset: `reset`=1 for 10 clk with bus idle (`scl`=`sda`=1) → `sda`=z, `busy`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0.
2. Single write: START, 0x6C (addr 0x36, W), data 0xA5, STOP →
   - `sda` pulled low during both 9th clocks.
   - Exactly one `rx_valid` pulse with `rx_data`=0xA5.
   - `rw`=0; `busy` falls within `SYNC_STAGES`+2 clk of STOP.
3. Single read: `tx_data`=0x5A, START, 0x6D, master NACK, STOP →
   - One `tx_req` pulse.
   - Master samples 0,1,0,1,1,0,1,0 on scl rises.
   - `sda`=z in the 9th clock; `rw`=1.
4. Burst read: `tx_data` 0x11 then 0x22 (changed after first `tx_req`), master ACK then NACK → two `tx_req` pulses, bytes 0x11, 0x22 on bus, `sda` released after second byte.
5. Address mismatch: START, 0x6E (addr 0x37), 0xFF, STOP → `sda` never driven, no `rx_valid`/`tx_req`, `busy`=1 until STOP.
6. Repeated START and reset:
   - Write 0x6C, then repeated START after 4 data bits, then 0x6D read → no `rx_valid` for the partial byte; read proceeds normally.
   - Assert `reset` during a read bit driving 0 → `sda`=z next clk, `busy`=0.
